// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// ---------------
// Bit-serial subtract sequencer. Two WIDTH-bit operands are captured when a
// request is accepted, then a single-bit subtract cell is stepped over them
// LSB-first, one bit per clock, with the borrow carried between bits in a
// register. The finished difference and final borrow are published together
// with a one-cycle done pulse. This trades latency (WIDTH+1 cycles of busy)
// for the area of a single 1-bit subtractor.
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rst    in   synchronous, active-high reset; aborts any operation
//   start  in   request, only looked at while idle
//   a      in   WIDTH-bit minuend, captured on the accepting edge
//   b      in   WIDTH-bit subtrahend, captured on the accepting edge
//   busy   out  high whenever an operation is running or completing
//   done   out  registered one-cycle pulse, d/b1 valid
//   d      out  WIDTH-bit difference a-b modulo 2^WIDTH
//   b1     out  final borrow, 1 when a < b (unsigned)

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b1
);

    // One extra bit lets the counter step past the last bit index without
    // wrapping, for any WIDTH in the legal range.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] dsh_q, dsh_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             b1_q, b1_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             xBit;
    logic             yBit;
    logic             bitDiff;
    logic             borrowNext;

    // The 1-bit subtract cell. It works on the LSBs of the shifting operand
    // registers and only the registered borrow, so there is no path from
    // the inputs to any output.
    always_comb begin
        xBit       = ra_q[0];
        yBit       = rb_q[0];
        bitDiff    = xBit ^ yBit ^ br_q;
        borrowNext = (~xBit & yBit) | (~(xBit ^ yBit) & br_q);
    end

    // State register and datapath registers. Reset clears everything,
    // including the published result, so an aborted run leaves d/b1 at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            dsh_q   <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            b1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            dsh_q   <= dsh_d;
            d_q     <= d_d;
            br_q    <= br_d;
            b1_q    <= b1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Each difference bit enters the shift register from
    // the top, so after WIDTH steps the LSB has arrived at bit 0. The
    // published result is loaded only on the final step; it holds through
    // idle and the whole of the following run.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        dsh_d   = dsh_q;
        d_d     = d_q;
        br_d    = br_q;
        b1_d    = b1_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    dsh_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                dsh_d = {bitDiff, dsh_q[WIDTH-1:1]};
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                br_d  = borrowNext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    d_d     = {bitDiff, dsh_q[WIDTH-1:1]};
                    b1_d    = borrowNext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign b1   = b1_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Testbench for serial_sub_ctrl. Drives directed operand pairs into an
// 8-bit instance, then runs long back-to-back sequences with start held
// high on both an 8-bit and a 13-bit instance.

module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  d8;
    logic        b18;

    logic        start13;
    logic [12:0] a13, b13;
    logic        busy13, done13;
    logic [12:0] d13;
    logic        b113;

    int checks = 0;
    int errors = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .d     (d8),
        .b1    (b18)
    );

    serial_sub_ctrl #(.WIDTH(13)) dut13 (
        .clk   (clk),
        .rst   (rst),
        .start (start13),
        .a     (a13),
        .b     (b13),
        .busy  (busy13),
        .done  (done13),
        .d     (d13),
        .b1    (b113)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expD;
        logic       expB1;
    } vec_t;

    vec_t vecs[7];

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one subtraction on the 8-bit instance from idle and check its
    // timing, busy window, single done pulse and result. Operands are
    // scrambled right after acceptance to show they were captured.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic [7:0] expD, input logic expB1,
                                 input string name);
        int edges;
        int busyCycles;
        bit seen;
        a8     = va;
        b8     = vb;
        start8 = 1'b1;
        @(negedge clk);
        start8     = 1'b0;
        a8         = ~va;
        b8         = vb ^ 8'h5A;
        edges      = 0;
        busyCycles = 0;
        seen       = 1'b0;
        while (!seen && edges <= 24) begin
            if (busy8) busyCycles++;
            if (done8) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                edges++;
            end
        end
        checkOutput({name, " done seen"}, 32'(seen), 32'd1);
        checkOutput({name, " latency"}, 32'(edges), 32'd8);
        checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'd9);
        checkOutput({name, " d"}, 32'(d8), 32'(expD));
        checkOutput({name, " b1"}, 32'(b18), 32'(expB1));
        @(negedge clk);
        checkOutput({name, " done cleared"}, 32'(done8), 32'd0);
        checkOutput({name, " busy cleared"}, 32'(busy8), 32'd0);
        checkOutput({name, " d held"}, 32'(d8), 32'(expD));
    endtask

    initial begin
        int doneCount;
        int doneAt;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, expD: 8'h1E, expB1: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, expD: 8'hFF, expB1: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, expD: 8'h00, expB1: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h7F, expD: 8'h01, expB1: 1'b0};
        vecs[4] = '{a: 8'h10, b: 8'h20, expD: 8'hF0, expB1: 1'b1};
        vecs[5] = '{a: 8'hC8, b: 8'h64, expD: 8'h64, expB1: 1'b0};
        vecs[6] = '{a: 8'h01, b: 8'h02, expD: 8'hFF, expB1: 1'b1};

        // Reset held for two edges with a live request: nothing may start.
        rst     = 1'b1;
        start8  = 1'b1;
        a8      = 8'hFF;
        b8      = 8'h01;
        start13 = 1'b1;
        a13     = 13'h1FFF;
        b13     = 13'h0001;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy8), 32'd0);
        checkOutput("reset done", 32'(done8), 32'd0);
        checkOutput("reset d", 32'(d8), 32'd0);
        checkOutput("reset b1", 32'(b18), 32'd0);
        checkOutput("reset busy w13", 32'(busy13), 32'd0);
        checkOutput("reset d w13", 32'(d13), 32'd0);
        rst     = 1'b0;
        start8  = 1'b0;
        start13 = 1'b0;
        @(negedge clk);
        checkOutput("post reset busy", 32'(busy8), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expD, vecs[i].expB1,
                          $sformatf("vec%0d", i));
        end

        // Extra start pulses and operand changes while running are ignored.
        $display("[TB] start/operand changes during run");
        a8     = 8'h5A;
        b8     = 8'h3C;
        start8 = 1'b1;
        @(negedge clk);
        doneCount = 0;
        doneAt    = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 2 || i == 4 || i == 6) begin
                start8 = 1'b1;
                a8     = 8'h11;
                b8     = 8'h22;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            if (done8) begin
                doneCount++;
                if (doneCount == 1) begin
                    doneAt = i;
                    checkOutput("ignore d", 32'(d8), 32'h1E);
                    checkOutput("ignore b1", 32'(b18), 32'd0);
                end
            end
        end
        checkOutput("ignore done count", 32'(doneCount), 32'd1);
        checkOutput("ignore done time", 32'(doneAt), 32'd8);
        checkOutput("ignore idle after", 32'(busy8), 32'd0);

        // Reset in the fourth run cycle aborts and clears the result.
        $display("[TB] reset mid-run");
        applyStimulus(8'h5A, 8'h3C, 8'h1E, 1'b0, "pre-abort");
        a8     = 8'h33;
        b8     = 8'h11;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort running", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy8), 32'd0);
        checkOutput("abort done", 32'(done8), 32'd0);
        checkOutput("abort d", 32'(d8), 32'd0);
        checkOutput("abort b1", 32'(b18), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        applyStimulus(8'h10, 8'h20, 8'hF0, 1'b1, "after abort");

        // Start held high: back-to-back operations on both widths.
        $display("[TB] back-to-back with start held high");
        fork
            begin : run8
                logic [7:0] ea, eb, ed;
                int cyc, prev, waitc;
                bit got;
                ea = 8'($urandom);
                eb = 8'($urandom);
                a8 = ea;
                b8 = eb;
                start8 = 1'b1;
                cyc  = 0;
                prev = 0;
                for (int op = 0; op < 1000; op++) begin
                    got   = 1'b0;
                    waitc = 0;
                    while (!got && waitc < 40) begin
                        @(negedge clk);
                        cyc++;
                        waitc++;
                        if (done8) got = 1'b1;
                    end
                    if (!got) begin
                        checkOutput("w8 timeout", 32'(got), 32'd1);
                        break;
                    end
                    ed = ea - eb;
                    checkOutput($sformatf("w8 op%0d d", op), 32'(d8), 32'(ed));
                    checkOutput($sformatf("w8 op%0d b1", op), 32'(b18),
                                32'(ea < eb));
                    if (op > 0)
                        checkOutput($sformatf("w8 op%0d spacing", op),
                                    32'(cyc - prev), 32'd10);
                    prev = cyc;
                    ea = 8'($urandom);
                    eb = 8'($urandom);
                    a8 = ea;
                    b8 = eb;
                end
                start8 = 1'b0;
            end
            begin : run13
                logic [12:0] ea, eb, ed;
                int cyc, prev, waitc;
                bit got;
                ea = 13'($urandom);
                eb = 13'($urandom);
                a13 = ea;
                b13 = eb;
                start13 = 1'b1;
                cyc  = 0;
                prev = 0;
                for (int op = 0; op < 1000; op++) begin
                    got   = 1'b0;
                    waitc = 0;
                    while (!got && waitc < 50) begin
                        @(negedge clk);
                        cyc++;
                        waitc++;
                        if (done13) got = 1'b1;
                    end
                    if (!got) begin
                        checkOutput("w13 timeout", 32'(got), 32'd1);
                        break;
                    end
                    ed = ea - eb;
                    checkOutput($sformatf("w13 op%0d d", op), 32'(d13), 32'(ed));
                    checkOutput($sformatf("w13 op%0d b1", op), 32'(b113),
                                32'(ea < eb));
                    if (op > 0)
                        checkOutput($sformatf("w13 op%0d spacing", op),
                                    32'(cyc - prev), 32'd15);
                    prev = cyc;
                    ea = 13'($urandom);
                    eb = 13'($urandom);
                    a13 = ea;
                    b13 = eb;
                end
                start13 = 1'b0;
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
